// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// One shift/add or restoring-subtract step per cycle, then a single sign-fix cycle.
module muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [4:0]  count_q;
  logic [31:0] acc_q, mq_q, opnd_q;
  logic        neg_q, rneg_q, bz_q, done_q;
  logic [31:0] hi_q, lo_q;

  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [31:0] acc_d, mq_d;
  logic [63:0] prod, prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign sgn   = ~op[0];
  assign a_mag = (sgn && a[31]) ? -a : a;
  assign b_mag = (sgn && b[31]) ? -b : b;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mul: {acc,mq} shifts right, opnd is the multiplicand.
  // div: {acc,mq} shifts left, mq collects quotient bits, opnd is the divisor.
  always_comb begin
    mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    div_shift = {acc_q, mq_q[31]};
    div_trial = div_shift - {1'b0, opnd_q};
    acc_d     = acc_q;
    mq_d      = mq_q;
    if (op_q[1]) begin
      if (!div_trial[32]) begin
        acc_d = div_trial[31:0];
        mq_d  = {mq_q[30:0], 1'b1};
      end else begin
        acc_d = div_shift[31:0];
        mq_d  = {mq_q[30:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[32:1];
      mq_d  = {mul_sum[0], mq_q[31:1]};
    end
  end

  // With a zero divisor every trial succeeds, so acc ends as |a| and the
  // remainder sign fix restores the original a; only LO needs overriding.
  always_comb begin
    prod     = {acc_q, mq_q};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = bz_q ? '1 : (neg_q ? -mq_q : mq_q);
    rem_fix  = rneg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      count_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            count_q <= '0;
            acc_q   <= '0;
            mq_q    <= op[1] ? a_mag : b_mag;
            opnd_q  <= op[1] ? b_mag : a_mag;
            neg_q   <= sgn & (a[31] ^ b[31]);
            rneg_q  <= sgn & a[31];
            bz_q    <= (b == '0);
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mq_q    <= mq_d;
          count_q <= count_q + 5'd1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic on the architectural values.
  task automatic model(input logic [1:0] o, input logic [31:0] x, y,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin sp = longint'(sx) * longint'(sy); {eh, el} = sp; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; {eh, el} = up; end
      2'b10: begin
        if (y == 0) begin el = 32'hFFFFFFFF; eh = x; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin el = 32'h80000000; eh = 0; end
        else begin el = sx / sy; eh = sx % sy; end
      end
      default: begin
        if (y == 0) begin el = 32'hFFFFFFFF; eh = x; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endtask

  // Caller is positioned #1 after a rising edge with the unit idle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, input string nm);
    logic [31:0] eh, el;
    int unsigned n;
    bit seen, bad;
    model(o, x, y, eh, el);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b want 1", nm, busy); end
    n = 0; seen = 0; bad = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1 || hi !== exp_hi || lo !== exp_lo) bad = 1;
    end
    checks++;
    if (!seen || n != 33) begin errors++; $display("FAIL %s latency: got seen=%0d edges=%0d want edges=33", nm, seen, n); end
    checks++;
    if (bad) begin errors++; $display("FAIL %s hold: busy dropped or hi/lo changed before done (got 1 want 0)", nm); end
    checks++;
    if (hi !== eh || lo !== el) begin errors++; $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, eh, el); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", nm, done, busy); end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; mthi = 0; mtlo = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    checks++;
    if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_multu_max();
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_max_const: got hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
  endtask

  task automatic test_signed();
    run_op(2'b00, -32'sd7, 32'sd6, "mult_neg");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6) begin
      errors++; $display("FAIL mult_neg_const: got hi=%h lo=%h want ffffffff ffffffd6", hi, lo);
    end
    run_op(2'b10, -32'sd7, 32'sd2, "div_neg");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_neg_const: got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
  endtask

  task automatic test_divide();
    run_op(2'b11, 32'd100, 32'd7, "divu");
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL divu_const: got hi=%h lo=%h want 2 e", hi, lo); end
    run_op(2'b10, 32'd5, 32'd0, "div_zero");
    checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero_const: got hi=%h lo=%h want 5 ffffffff", hi, lo); end
    run_op(2'b10, 32'h80000005, 32'd0, "div_zero_neg");
    run_op(2'b11, 32'h80000005, 32'd0, "divu_zero");
  endtask

  task automatic test_overflow();
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    checks++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_const: got hi=%h lo=%h want 0 80000000", hi, lo); end
  endtask

  task automatic test_moves();
    mthi = 1; a = 32'h12345678;
    @(posedge clk); #1 mthi = 0;
    checks++;
    if (hi !== 32'h12345678 || lo !== exp_lo || done !== 0) begin
      errors++; $display("FAIL mthi: got hi=%h lo=%h done=%b want 12345678 %h 0", hi, lo, done, exp_lo);
    end
    exp_hi = 32'h12345678;
    mtlo = 1; a = 32'hCAFEF00D;
    @(posedge clk); #1 mtlo = 0;
    checks++;
    if (lo !== 32'hCAFEF00D || hi !== exp_hi || done !== 0) begin
      errors++; $display("FAIL mtlo: got hi=%h lo=%h done=%b want %h cafef00d 0", hi, lo, done, exp_hi);
    end
    exp_lo = 32'hCAFEF00D;
    mthi = 1; mtlo = 1; a = 32'h0BADBEEF;
    @(posedge clk); #1 mthi = 0; mtlo = 0;
    checks++;
    if (hi !== 32'h0BADBEEF || lo !== 32'h0BADBEEF) begin
      errors++; $display("FAIL mt_both: got hi=%h lo=%h want 0badbeef 0badbeef", hi, lo);
    end
    exp_hi = 32'h0BADBEEF; exp_lo = 32'h0BADBEEF;
    // start wins over a simultaneous move
    start = 1; mtlo = 1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(posedge clk); #1 start = 0; mtlo = 0;
    checks++;
    if (lo !== exp_lo || busy !== 1) begin errors++; $display("FAIL start_wins: got lo=%h busy=%b want %h 1", lo, busy, exp_lo); end
    repeat (33) @(posedge clk);
    #1;
    checks++;
    if (done !== 1 || hi !== 0 || lo !== 32'd81) begin
      errors++; $display("FAIL start_wins_result: got done=%b hi=%h lo=%h want 1 0 51", done, hi, lo);
    end
    exp_hi = 0; exp_lo = 32'd81;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int unsigned n, dones;
    logic [31:0] eh, el;
    model(2'b00, 32'hFFFF1234, 32'h00007777, eh, el);
    start = 1; op = 2'b00; a = 32'hFFFF1234; b = 32'h00007777;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 start = 1; mtlo = 1; mthi = 1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1 start = 0; mtlo = 0; mthi = 0;
    dones = 0;
    for (n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      if (done === 1) dones++;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL busy_ignore_dones: got %0d want 1", dones); end
    checks++;
    if (hi !== eh || lo !== el || busy !== 0) begin
      errors++; $display("FAIL busy_ignore_result: got hi=%h lo=%h busy=%b want %h %h 0", hi, lo, busy, eh, el);
    end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic test_reset_mid();
    int unsigned dones;
    start = 1; op = 2'b01; a = 32'hDEAD0001; b = 32'h00010003;
    @(posedge clk); #1 start = 0;
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    checks++;
    if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    dones = 0;
    for (int unsigned n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1 || busy === 1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d done/busy cycles want 0", dones); end
    exp_hi = 0; exp_lo = 0;
    run_op(2'b01, 32'd3, 32'd4, "multu_after_reset");
    checks++;
    if (hi !== 0 || lo !== 32'd12) begin errors++; $display("FAIL multu_after_reset_const: got hi=%h lo=%h want 0 c", hi, lo); end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [1:0]  o;
    for (int unsigned i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 6 == 1) y = y >> $urandom_range(16, 31);
      if (i % 6 == 3) x = -x;
      if (i % 6 == 5) y = 32'hFFFFFFFF;
      run_op(o, x, y, "random");
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_divide();
    test_overflow();
    test_moves();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the MIPS CPU, directly downstream of the register file: it consumes the two register read operands (`data1`, `data2`) in the execute stage and holds the architectural HI/LO registers. It implements MULT, MULTU, DIV and DIVU with a 32-iteration shift/add or restoring-subtract datapath. It also implements MTHI and MTLO. While an operation is in flight, `busy` stalls the pipeline.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` in 1 — clock; all state changes on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `start` in 1 — begin operation `op` on `a`/`b`; sampled only when idle.
- `op` in 2 — 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in 32 — rs operand (register file `data1`); multiplicand or dividend.
- `b` in 32 — rt operand (register file `data2`); multiplier or divisor.
- `mthi` in 1 — write `a` to HI; honoured only when idle.
- `mtlo` in 1 — write `a` to LO; honoured only when idle.
- `busy` out 1 — operation in flight; the pipeline must stall MFHI/MFLO and new mul/div.
- `done` out 1 — one-cycle pulse when HI/LO hold a new result.
- `hi` out 32 — HI register.
- `lo` out 32 — LO register.

## Operation
- **States:** IDLE, RUN, FIX.
- **Reset:** state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, iteration count=0.
- **IDLE + `start`:**
  - Latch `op`.
  - Latch operand magnitudes: absolute values for the signed ops, raw values for the unsigned ops.
  - Latch the result sign flags.
  - count=0, go to RUN.
- **IDLE, no `start`:**
  - `mthi` → `hi`<=`a`.
  - `mtlo` → `lo`<=`a`.
  - Both asserted → both written.
- **`start` together with `mthi`/`mtlo`:** `start` wins; the move is dropped.
- **RUN, one iteration per cycle, count 0..31:**
  - Multiply: 64-bit {acc, multiplier} shift/add, unsigned on magnitudes.
  - Divide: restoring algorithm, 33-bit trial subtract on magnitudes, quotient bit shifted in.
  - After count==31, go to FIX.
- **FIX (one cycle):** apply sign correction, write `hi`/`lo`, set `done`, go to IDLE.
  - MULT: 64-bit product negated if sign(a)≠sign(b); HI=upper 32 bits, LO=lower 32 bits.
  - DIV: quotient negated if the signs differ. The remainder takes the sign of `a`. LO=quotient, HI=remainder.
  - Unsigned ops: no correction.
- **Divide by zero, any sign:** LO=32'hFFFFFFFF, HI=`a` as originally presented. The full latency still applies.
- **Signed overflow** (DIV with `a`=32'h80000000, `b`=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- **Ignored inputs:** `start`, `mthi` and `mtlo` are ignored while `busy`. No queueing.
- **Input stability:** `a`/`b` are sampled only on the accepting edge and need not stay stable afterwards.

## Timing
- Let E be the edge where `start` is accepted.
- `busy`=1 from the cycle after E through the cycle after edge E+32, spanning 33 cycles (32 RUN + 1 FIX).
- Edge E+33 (FIX edge) updates `hi`/`lo` and sets `done`=1. In the following cycle `busy`=0, so a new `start` can be accepted at edge E+34.
- `done` is high for exactly one cycle, then clears.
- Result latency from the start edge to visible HI/LO is 34 cycles.
- `mthi`/`mtlo` take effect at the sampling edge and are visible the next cycle. `done` is not pulsed.
- `hi`/`lo` keep their old values throughout RUN. Only FIX, MTHI, MTLO or reset modify them.
- **Reset mid-operation:** the operation is aborted, all outputs return to reset values on that edge, and no `done` pulse is generated.

## Test plan
- **Unsigned multiply:** MULTU `a`=32'hFFFFFFFF, `b`=32'hFFFFFFFF.
  - `busy` rises the cycle after start and `done` pulses 34 cycles after start.
  - `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- **Signed multiply and signed divide:**
  - MULT `a`=-7, `b`=6 → `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFD6 (-42).
  - DIV `a`=-7, `b`=2 → `lo`=32'hFFFFFFFD (-3), `hi`=32'hFFFFFFFF (-1).
- **Unsigned divide, then divide-by-zero:**
  - DIVU 100/7 → `lo`=14, `hi`=2.
  - DIV 5/0 → `lo`=32'hFFFFFFFF, `hi`=5, with 34-cycle latency.
- **Signed overflow:** DIV 32'h80000000 / 32'hFFFFFFFF → `lo`=32'h80000000, `hi`=0.
- **Moves, and inputs while busy:**
  - In IDLE: `mthi` with `a`=32'h12345678 → `hi`=32'h12345678 the next cycle. `mtlo` works the same way for `lo`.
  - During RUN: a second `start` with different operands, plus `mtlo`, are both ignored. The original result is delivered and no second `done` pulse occurs.
- **Reset mid-operation:** assert `reset` at RUN count 10 → `busy`=0, `hi`=`lo`=0, and `done` never pulses. A new MULTU 3×4 afterwards yields `lo`=12, `hi`=0.
